// File: rtl/sobel_frame_writer_if.sv
// Stream-in / BRAM-write bundle for sobel_frame_writer.
// Optional threshold input appears when SOBEL_WR_BINARIZE_EN is defined.
interface sobel_frame_writer_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  in_pixel;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic              busy;
  logic              done;
`ifdef SOBEL_WR_BINARIZE_EN
  logic [PIX_W-1:0]  threshold;

  modport master (
    output start, in_valid, in_pixel, threshold,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );
  modport slave (
    input  start, in_valid, in_pixel, threshold,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );
`else
  modport master (
    output start, in_valid, in_pixel,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );
  modport slave (
    input  start, in_valid, in_pixel,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done
  );
`endif
endinterface

// File: rtl/sobel_frame_writer.sv
// Raster-walks an IMG_W x IMG_H frame, writing Sobel results to interior pixels and 0 to borders.
// Define SOBEL_WR_BINARIZE_EN to threshold interior results to all-ones / zero.
module sobel_frame_writer #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 17,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  sobel_frame_writer_if.slave   bus
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | walking the frame, one position per advance
  // DONE  | frame complete; held until start is low
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [1:0]        state;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] addr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  wdata_q;

  logic             border;
  logic             advance;
  logic             last_pos;
  logic [PIX_W-1:0] interior_val;

  assign border   = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  assign last_pos = (row == ROW_LAST) && (col == COL_LAST);
  assign advance  = (state == RUN) && (border || bus.in_valid);

`ifdef SOBEL_WR_BINARIZE_EN
  assign interior_val = (bus.in_pixel >= bus.threshold) ? {PIX_W{1'b1}} : '0;
`else
  assign interior_val = bus.in_pixel;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      addr    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            row   <= '0;
            col   <= '0;
            addr  <= ADDR_W'(BASE_ADDR);
          end
        end
        RUN: begin
          if (advance) begin
            we_q    <= 1'b1;
            addr_q  <= addr;
            wdata_q <= border ? '0 : interior_val;
            addr    <= addr + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pos) state <= DONE;
          end
        end
        DONE: begin
          if (!bus.start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == RUN) && !border;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Scoreboard bench for sobel_frame_writer on a 4x4 frame.
// Build with SOBEL_WR_BINARIZE_EN defined to check the thresholded image instead.
module tb_sobel_frame_writer;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 17;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
    logic              done;
  } wr_t;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;
  int   wr_count = 0;
  wr_t  exp_q[$];

  logic [PIX_W-1:0] pix[4];
  logic [PIX_W-1:0] exp_int[4];

  sobel_frame_writer_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  sobel_frame_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .BASE_ADDR(0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_t act, expv;
      wr_count++;
      act = '{addr: bus.mem_addr, data: bus.mem_wdata, done: bus.done};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                 act.addr, act.data);
      end else begin
        expv = exp_q.pop_front();
        if (act != expv) begin
          fails++;
          $display("FAIL write: got addr %0d data %0d done %0d, expected addr %0d data %0d done %0d",
                   act.addr, act.data, act.done, expv.addr, expv.data, expv.done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame; abort_addr >= 0 pulls reset while that address's write is visible.
  task automatic run_frame(input bit alt, input int abort_addr, input bit hold_start,
                           input string tag);
    int hs = 0;
    int cyc = 0;
    int k = 0;
    int last_a;
    bit aborted = 0;
    last_a = (abort_addr >= 0) ? abort_addr : IMG_W * IMG_H - 1;
    for (int a = 0; a <= last_a; a++) begin
      int r = a / IMG_W;
      int c = a % IMG_W;
      logic [PIX_W-1:0] d;
      if (r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1) d = '0;
      else d = exp_int[k++];
      exp_q.push_back('{addr: ADDR_W'(a), data: d, done: (a == IMG_W * IMG_H - 1)});
    end
    bus.start = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
    while (cyc < 200) begin
      bus.in_valid = alt ? (cyc % 2 == 0) : 1'b1;
      bus.in_pixel = (hs < 4) ? pix[hs] : '0;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) hs++;
      tick();
      cyc++;
      if (abort_addr >= 0 && bus.mem_we && bus.mem_addr == ADDR_W'(abort_addr)) begin
        rstn = 1'b0;
        aborted = 1;
        break;
      end
      if (bus.done) break;
    end
    bus.in_valid = 1'b0;
    if (abort_addr >= 0) begin
      check({tag, "_abort_reached"}, aborted, 1);
      tick();
      tick();
      check({tag, "_busy_after_reset"}, bus.busy, 0);
      check({tag, "_we_after_reset"}, bus.mem_we, 0);
      rstn = 1'b1;
    end else begin
      check({tag, "_done_seen"}, bus.done, 1);
      check({tag, "_handshakes"}, hs, 4);
      check({tag, "_run_cycles"}, cyc, alt ? IMG_W * IMG_H + 4 : IMG_W * IMG_H);
    end
    @(negedge clk);
    #1;
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int wc;
    bit stay;
    pix[0] = 8'd10; pix[1] = 8'd20; pix[2] = 8'd30; pix[3] = 8'd40;
`ifdef SOBEL_WR_BINARIZE_EN
    exp_int[0] = 8'h00; exp_int[1] = 8'h00; exp_int[2] = 8'hFF; exp_int[3] = 8'hFF;
    bus.threshold = 8'd25;
`else
    exp_int[0] = 8'd10; exp_int[1] = 8'd20; exp_int[2] = 8'd30; exp_int[3] = 8'd40;
`endif

    // Reset with start and in_valid asserted
    rstn = 1'b0;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pixel = '0;
    tick();
    check("reset_outputs", {bus.mem_we, bus.in_ready, bus.busy, bus.done}, 0);
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    wc = wr_count;
    for (int i = 0; i < 5; i++) tick();
    check("reset_idle_busy", bus.busy, 0);
    check("reset_idle_writes", wr_count - wc, 0);

    run_frame(1'b0, -1, 1'b0, "full");
    tick();
    check("full_back_to_idle", {bus.busy, bus.done}, 0);

    run_frame(1'b1, -1, 1'b0, "bp");
    tick();

    run_frame(1'b0, 6, 1'b0, "midrst");
    run_frame(1'b0, -1, 1'b0, "restart");
    tick();

    run_frame(1'b0, -1, 1'b1, "hold");
    wc = wr_count;
    stay = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.done || bus.busy) stay = 0;
    end
    check("hold_done_stays", stay, 1);
    check("hold_no_writes", wr_count - wc, 0);
    bus.start = 1'b0;
    tick();
    check("hold_release_idle", {bus.busy, bus.done}, 0);
    run_frame(1'b0, -1, 1'b0, "after_hold");

    for (int i = 0; i < 3; i++) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
